mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It arbitrates requests, sequences the variable-latency memory handshake and returns read data to the winning port. It also drives the stall signals the pipeline registers use, and flags a memory that never answers.

Parameters:
ADDR_W, 32, byte-address width on all ports
TIMEOUT_CYCLES, 16, maximum BUSY cycles without mem_ready before a transaction is aborted; legal range 2..255

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
if_req  in  1  fetch request, level; held until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  32  fetched instruction, meaningful while if_valid
if_valid  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request, level; held until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  32  store data
dm_rdata  out  32  load data, meaningful while dm_valid
dm_valid  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled only in BUSY states
stall_if  out  1  hold PC and IF/ID register
stall_pipe  out  1  hold ID/EX, EX/MEM and IF/ID; bubble MEM/WB
timeout_err  out  1  sticky abort flag

Behaviour:
- Clocking: one clock; reset is synchronous and active-high, ports clk and reset.
- Reset values: state IDLE; mem_req, mem_we, if_valid, dm_valid, timeout_err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; wait counter = 0.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE, arbitration:
  - dm_req wins over if_req. The data access belongs to the older instruction, so there is fixed priority and no fairness counter.
  - On grant, register the address, we and wdata into the mem_* outputs and set mem_req = 1. Next state is BUSY_DM or BUSY_IF.
  - For a fetch, mem_we = 0 and mem_wdata = 0.
- Same-cycle re-grant guard: a port whose valid is high this cycle is excluded from arbitration this cycle.
- BUSY_x:
  - mem_req and the mem_* outputs stay stable. The wait counter increments each cycle.
  - On mem_ready = 1: capture mem_rdata into x_rdata (stores capture mem_rdata as-is), pulse x_valid next cycle, drop mem_req and mem_we, return to IDLE, clear the counter.
- Latency: grant at cycle 0, mem_req high from cycle 1, mem_ready at cycle k ≥ 1, x_valid at cycle k+1. IDLE may grant a new request in cycle k+1, so back-to-back transactions cost one IDLE cycle each.
- Timeout:
  - If the counter reaches TIMEOUT_CYCLES with no mem_ready, abort.
  - Abort pulses x_valid with x_rdata = 32'h0, sets timeout_err, drops mem_req and returns to IDLE.
  - timeout_err stays set until reset.
  - If mem_ready arrives in the same cycle the counter hits the limit, mem_ready wins: normal completion, no error.
- Stalls (combinational):
  - stall_pipe = dm_req & ~dm_valid.
  - stall_if = (if_req & ~if_valid) | stall_pipe.
- Boundary cases:
  - mem_ready high in IDLE is ignored.
  - A request dropped while BUSY does not abort the transaction; its valid still pulses.
  - Reset mid-transaction returns to IDLE and drops mem_req in the next cycle. The abandoned memory access is the memory's problem.
  - if_req and dm_req both high with the arbiter BUSY: both wait.

Decomposition:
- Add to the common package:
  - arb_state_type enum {IDLE, BUSY_IF, BUSY_DM}.
  - mem_req_type packed struct {addr, wdata, we} for the registered memory-side request.
  - Constant DEFAULT_TIMEOUT = 16.
- Sub-module wait_timer: a saturating counter with clear/enable inputs and an expired output, sized by $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- if_req=1, if_addr=0x40, mem_ready high 3 cycles after mem_req rises, mem_rdata=0x00500093 -> if_valid pulses one cycle later with if_rdata=0x00500093; mem_we=0 throughout.
- if_req and dm_req rise together (dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF), memory replies with mem_ready after 1 cycle -> data first with mem_addr=0x100, mem_we=1, mem_wdata=0xDEADBEEF. Fetch is granted in the IDLE cycle after dm_valid. stall_pipe falls on dm_valid.
- Load at 0x200 whose requester holds dm_req through the dm_valid cycle -> exactly one dm_valid pulse and no second memory transaction.
- mem_ready held low, TIMEOUT_CYCLES=16 -> abort after 16 BUSY cycles: dm_valid pulses with dm_rdata=0, timeout_err=1 and stays 1 until reset.
- mem_ready arrives in exactly the limit cycle -> normal completion with the real data; timeout_err stays 0.
- reset asserted in BUSY_DM mid-wait -> mem_req=0 and state IDLE on the next edge, no dm_valid pulse, all outputs at reset values.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 16;
    // Widest byte address the registered request can carry.
    localparam int unsigned MAX_ADDR_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM
    } arb_state_type;

    // Registered memory-side request, held stable while a transaction is open.
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic                  we;
    } mem_req_type;

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Saturating BUSY-cycle counter; flags the cycle in which the wait limit is reached.
module wait_timer
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] CNT_MAX  = W'(LIMIT);
    localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over count; the count never wraps past LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of earlier BUSY cycles, so the LIMIT-th BUSY cycle
    // is the one that sees cnt_q == LIMIT-1.
    assign expired_o = en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port memory between IF and MEM stages.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_pipe,
    output logic              timeout_err
);

    arb_state_type state_q, state_d;
    mem_req_type   req_q, req_d;
    logic          mem_req_q, mem_req_d;
    logic          if_valid_q, if_valid_d;
    logic          dm_valid_q, dm_valid_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          finish;
    logic          expired;

    wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i     (clk),
        .reset_i   (reset),
        .clr_i     ((state_q == IDLE) || finish),
        .en_i      (state_q != IDLE),
        .expired_o (expired)
    );

    // Arbitration, handshake sequencing and completion/abort bookkeeping.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        mem_req_d  = mem_req_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;
        finish     = 1'b0;
        case (state_q)
            IDLE: begin
                // A port whose valid is showing this cycle is still holding its
                // old request, so it must not be granted again.
                if (dm_req && !dm_valid_q) begin
                    req_d.addr  = MAX_ADDR_W'(dm_addr);
                    req_d.wdata = dm_wdata;
                    req_d.we    = dm_we;
                    mem_req_d   = 1'b1;
                    state_d     = BUSY_DM;
                end else if (if_req && !if_valid_q) begin
                    req_d.addr  = MAX_ADDR_W'(if_addr);
                    req_d.wdata = '0;
                    req_d.we    = 1'b0;
                    mem_req_d   = 1'b1;
                    state_d     = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                // mem_ready takes precedence over an expiry in the same cycle.
                if (mem_ready || expired) begin
                    finish    = 1'b1;
                    mem_req_d = 1'b0;
                    req_d.we  = 1'b0;
                    state_d   = IDLE;
                    if (!mem_ready) begin
                        err_d = 1'b1;
                    end
                    if (state_q == BUSY_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = mem_ready ? mem_rdata : '0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            mem_req_q  <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            mem_req_q  <= mem_req_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = req_q.we;
    assign mem_addr    = req_q.addr[ADDR_W-1:0];
    assign mem_wdata   = req_q.wdata;
    assign if_valid    = if_valid_q;
    assign if_rdata    = if_rdata_q;
    assign dm_valid    = dm_valid_q;
    assign dm_rdata    = dm_rdata_q;
    assign timeout_err = err_q;

    assign stall_pipe  = dm_req & ~dm_valid_q;
    assign stall_if    = (if_req & ~if_valid_q) | stall_pipe;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_valid, dm_valid, mem_req, mem_we;
    logic        stall_if, stall_pipe, timeout_err;

    mem_arbiter #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_valid    (dm_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .stall_if    (stall_if),
        .stall_pipe  (stall_pipe),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner 0 = none, 1 = fetch, 2 = data; age = BUSY cycles so far.
    int          m_owner = 0;
    int          m_age   = 0;
    logic        m_mem_req = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
    logic        m_if_valid = 1'b0, m_dm_valid = 1'b0, m_err = 1'b0;

    // Memory responder: answers in BUSY cycle number lat (0 = never).
    int          lat = 1;
    logic [31:0] next_rdata = '0;
    bit          rand_lat = 1'b0;
    bit          idle_noise = 1'b0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic        old_ifv, old_dmv;
        logic [31:0] data;
        if (reset) begin
            m_owner = 0; m_age = 0; m_mem_req = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
            m_if_valid = 0; m_dm_valid = 0; m_err = 0;
            return;
        end
        old_ifv = m_if_valid;
        old_dmv = m_dm_valid;
        m_if_valid = 1'b0;
        m_dm_valid = 1'b0;
        if (m_owner == 0) begin
            if (dm_req && !old_dmv) begin
                m_owner = 2; m_age = 0; m_mem_req = 1;
                m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
            end else if (if_req && !old_ifv) begin
                m_owner = 1; m_age = 0; m_mem_req = 1;
                m_addr = if_addr; m_we = 0; m_wdata = '0;
            end
        end else begin
            m_age++;
            if (mem_ready || m_age == TMO) begin
                data = mem_ready ? mem_rdata : 32'h0;
                if (m_owner == 1) begin m_if_valid = 1; m_if_rdata = data; end
                else              begin m_dm_valid = 1; m_dm_rdata = data; end
                if (!mem_ready) m_err = 1;
                m_owner = 0; m_mem_req = 0; m_we = 0;
            end
        end
    endtask

    task automatic pick_lat();
        int unsigned r = $urandom_range(9);
        case (r)
            0:       lat = 0;
            1:       lat = TMO;
            2:       lat = TMO + 1;
            3:       lat = TMO - 1;
            default: lat = 1 + int'($urandom_range(4));
        endcase
        next_rdata = $urandom;
    endtask

    task automatic check_outputs();
        chk1 ("mem_req",     mem_req,     m_mem_req);
        chk1 ("mem_we",      mem_we,      m_we);
        chk32("mem_addr",    mem_addr,    m_addr);
        chk32("mem_wdata",   mem_wdata,   m_wdata);
        chk1 ("if_valid",    if_valid,    m_if_valid);
        chk1 ("dm_valid",    dm_valid,    m_dm_valid);
        chk32("if_rdata",    if_rdata,    m_if_rdata);
        chk32("dm_rdata",    dm_rdata,    m_dm_rdata);
        chk1 ("timeout_err", timeout_err, m_err);
    endtask

    // One clock cycle: inputs already set by the caller just after a negedge.
    task automatic tick();
        int prev_owner;
        if (m_owner != 0) mem_ready = (lat != 0) && (m_age + 1 == lat);
        else              mem_ready = idle_noise && ($urandom_range(3) == 0);
        mem_rdata = mem_ready ? next_rdata : $urandom;
        #1;
        chk1("stall_pipe", stall_pipe, dm_req & ~m_dm_valid);
        chk1("stall_if",   stall_if,   (if_req & ~m_if_valid) | (dm_req & ~m_dm_valid));
        prev_owner = m_owner;
        model_step();
        if (rand_lat && prev_owner == 0 && m_owner != 0) pick_lat();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int  cnt;
        int  pulses;
        bit  if_done, dm_done;

        reset = 1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_ready = 0; mem_rdata = '0;
        tick();
        tick();
        reset = 0;
        tick();

        // Fetch at 0x40, memory answers in the 4th BUSY cycle.
        if_req = 1; if_addr = 32'h40; lat = 4; next_rdata = 32'h0050_0093;
        cnt = 0;
        while (!m_if_valid && cnt < 30) begin
            tick(); cnt++;
            chk1("t1_mem_we", mem_we, 1'b0);
        end
        chk32("t1_latency", cnt, 5);
        chk1 ("t1_if_valid", if_valid, 1'b1);
        chk32("t1_if_rdata", if_rdata, 32'h0050_0093);
        if_req = 0;
        tick();
        chk1("t1_pulse_end", if_valid, 1'b0);

        // Simultaneous requests: data wins, fetch follows in the dm_valid cycle.
        if_req = 1; if_addr = 32'h80;
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        lat = 1; next_rdata = 32'h1234_5678;
        tick();
        chk1 ("t2_mem_req",   mem_req,   1'b1);
        chk1 ("t2_mem_we",    mem_we,    1'b1);
        chk32("t2_mem_addr",  mem_addr,  32'h100);
        chk32("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk1("t2_dm_valid", dm_valid, 1'b1);
        #1;
        chk1("t2_stall_pipe_low", stall_pipe, 1'b0);
        lat = 2; next_rdata = 32'h0000_0013;
        tick();
        dm_req = 0;
        chk1 ("t2_if_granted", mem_req,  1'b1);
        chk32("t2_if_addr",    mem_addr, 32'h80);
        chk1 ("t2_if_we",      mem_we,   1'b0);
        cnt = 0;
        while (!m_if_valid && cnt < 30) begin tick(); cnt++; end
        chk1("t2_if_valid", if_valid, 1'b1);
        if_req = 0;
        tick();

        // Load held through its dm_valid cycle: one pulse, no second access.
        dm_req = 1; dm_we = 0; dm_addr = 32'h200; lat = 2; next_rdata = 32'hA5A5_0001;
        cnt = 0;
        while (!m_dm_valid && cnt < 30) begin tick(); cnt++; end
        pulses = int'(dm_valid);
        tick();
        pulses += int'(dm_valid);
        chk1("t3_no_regrant", mem_req, 1'b0);
        dm_req = 0;
        for (int i = 0; i < 4; i++) begin tick(); pulses += int'(dm_valid); end
        chk32("t3_pulses", pulses, 1);
        chk32("t3_dm_rdata", dm_rdata, 32'hA5A5_0001);

        // Memory never answers: abort after TMO BUSY cycles.
        dm_req = 1; dm_we = 0; dm_addr = 32'h300; lat = 0;
        cnt = 0;
        while (!m_dm_valid && cnt < 40) begin tick(); cnt++; end
        chk32("t4_latency",  cnt, TMO + 1);
        chk1 ("t4_dm_valid", dm_valid, 1'b1);
        chk32("t4_dm_rdata", dm_rdata, 32'h0);
        chk1 ("t4_err",      timeout_err, 1'b1);
        chk1 ("t4_mem_req",  mem_req, 1'b0);
        dm_req = 0;
        tick();
        if_req = 1; if_addr = 32'h44; lat = 1; next_rdata = 32'h0000_0093;
        cnt = 0;
        while (!m_if_valid && cnt < 30) begin tick(); cnt++; end
        if_req = 0;
        tick();
        chk1("t4_err_sticky", timeout_err, 1'b1);
        reset = 1;
        tick();
        reset = 0;
        chk1("t4_err_cleared", timeout_err, 1'b0);

        // mem_ready in exactly the limit cycle completes normally.
        dm_req = 1; dm_we = 0; dm_addr = 32'h400; lat = TMO; next_rdata = 32'hCAFE_F00D;
        cnt = 0;
        while (!m_dm_valid && cnt < 40) begin tick(); cnt++; end
        chk32("t5_latency",  cnt, TMO + 1);
        chk32("t5_dm_rdata", dm_rdata, 32'hCAFE_F00D);
        chk1 ("t5_err",      timeout_err, 1'b0);
        dm_req = 0;
        tick();

        // Reset in the middle of a data wait.
        dm_req = 1; dm_we = 1; dm_addr = 32'h500; dm_wdata = 32'h1111_2222; lat = 0;
        for (int i = 0; i < 5; i++) tick();
        chk1("t6_busy", mem_req, 1'b1);
        reset = 1;
        tick();
        chk1 ("t6_mem_req",  mem_req,  1'b0);
        chk1 ("t6_mem_we",   mem_we,   1'b0);
        chk32("t6_mem_addr", mem_addr, 32'h0);
        reset = 0; dm_req = 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin tick(); pulses += int'(dm_valid); end
        chk32("t6_no_valid", pulses, 0);

        // Randomized traffic with random latencies, drops, idle noise and resets.
        rand_lat = 1; idle_noise = 1; if_done = 0; dm_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(299) == 0);
            if (if_done) begin if_req = 0; if_done = 0; end
            if (!if_req) begin
                if ($urandom_range(2) == 0) begin if_req = 1; if_addr = $urandom; end
            end else if (!m_if_valid && $urandom_range(49) == 0) begin
                if_req = 0;
            end
            if (if_req && m_if_valid) if_done = 1;
            if (dm_done) begin dm_req = 0; dm_done = 0; end
            if (!dm_req) begin
                if ($urandom_range(2) == 0) begin
                    dm_req = 1; dm_we = ($urandom_range(1) == 1);
                    dm_addr = $urandom; dm_wdata = $urandom;
                end
            end else if (!m_dm_valid && $urandom_range(49) == 0) begin
                dm_req = 0;
            end
            if (dm_req && m_dm_valid) dm_done = 1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
